// File: rtl/gated_mac_pkg.sv
// Shared types for the gated multiply-accumulate sequencer: FSM states and the
// wrap/saturate adder used for both the bias/prev load and per-channel accumulate.
package gated_mac_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic        ovf;
        logic [63:0] sum;
    } sat_res_t;

    // Adds in an (ow+1)-bit adder; a carry out of bit ow-1 flags overflow and
    // either wraps to the low ow bits or clamps to 2^ow-1.
    function automatic sat_res_t sat_add(input logic [63:0] a, input logic [63:0] b,
                                         input int ow, input logic sat);
        logic [63:0] mask;
        logic [63:0] s;
        sat_res_t    r;
        mask  = (64'd1 << ow) - 64'd1;
        s     = (a + b) & ((mask << 1) | 64'd1);
        r.ovf = s[ow];
        r.sum = r.ovf ? (sat ? mask : (s & mask)) : s;
        return r;
    endfunction

endpackage

// File: rtl/gmac_mul.sv
// Combinational AW x BW unsigned multiplier, kept separate so a pipelined
// version can drop in without touching the sequencer.
module gmac_mul #(
    parameter int AW = 9,
    parameter int BW = 8
) (
    input  logic [AW-1:0]    a,
    input  logic [BW-1:0]    b,
    output logic [AW+BW-1:0] p
);

    assign p = (AW+BW)'(a) * (AW+BW)'(b);

endmodule

// File: rtl/gated_mac_seq.sv
// Gated sum-of-products, one channel per cycle: result valid NCH+1 cycles after accept.
// in_ready only in IDLE; result held in DONE until out_ready, then becomes prev.
module gated_mac_seq
    import gated_mac_pkg::*;
#(
    parameter int NCH   = 6,
    parameter int AW    = 9,
    parameter int BW    = 8,
    parameter int BIASW = 7,
    parameter int OW    = 17,
    parameter int SAT   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NCH*AW-1:0]  in_a,
    input  logic [NCH*BW-1:0]  in_b,
    input  logic [NCH-1:0]     in_gate,
    input  logic [BIASW-1:0]   in_bias,
    input  logic               in_acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OW-1:0]      out_data,
    output logic               out_ovf
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = AW + BW;

    state_t              state;
    state_t              state_nxt;
    logic [NCH*AW-1:0]   a_q;
    logic [NCH*BW-1:0]   b_q;
    logic [NCH-1:0]      gate_q;
    logic [IW-1:0]       idx;
    logic [OW-1:0]       acc;
    logic [OW-1:0]       prev;
    logic                ovf;
    logic                out_valid_q;

    logic [AW-1:0]       a_sel;
    logic [BW-1:0]       b_sel;
    logic [PW-1:0]       prod;
    logic [OW:0]         prod_ext;
    sat_res_t            load_res;
    sat_res_t            step_res;
    logic                last_idx;
    logic                accept;
    logic                unused_hi;

    assign a_sel = a_q[idx*AW +: AW];
    assign b_sel = b_q[idx*BW +: BW];

    gmac_mul #(.AW(AW), .BW(BW)) u_mul (
        .a (a_sel),
        .b (b_sel),
        .p (prod)
    );

    assign prod_ext = gate_q[idx] ? '0 : (OW+1)'(prod);
    assign load_res = sat_add(64'(in_bias), in_acc_clr ? 64'd0 : 64'(prev), OW, SAT != 0);
    assign step_res = sat_add(64'(acc), 64'(prod_ext), OW, SAT != 0);
    assign unused_hi = ^{load_res.sum[63:OW], step_res.sum[63:OW]};

    assign last_idx = (idx == IW'(NCH-1));
    assign accept   = in_valid && (state == IDLE);
    assign in_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_idx)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            gate_q      <= '0;
            idx         <= '0;
            acc         <= '0;
            prev        <= '0;
            ovf         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q    <= in_a;
                b_q    <= in_b;
                gate_q <= in_gate;
                acc    <= load_res.sum[OW-1:0];
                ovf    <= load_res.ovf;
                idx    <= '0;
            end
            if (state == RUN) begin
                acc <= step_res.sum[OW-1:0];
                ovf <= ovf | step_res.ovf;
                // idx parks at 0 after the last channel so the operand mux never indexes past NCH-1
                if (last_idx) begin
                    idx         <= '0;
                    out_valid_q <= 1'b1;
                end else begin
                    idx <= idx + IW'(1);
                end
            end
            if ((state == DONE) && out_ready) begin
                prev        <= acc;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = acc;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_gated_mac_seq.sv
// Drives a wrapping and a saturating instance in lockstep and checks both against
// a plain-arithmetic model of the gated sum of products.
module tb_gated_mac_seq;

    localparam int NCH   = 6;
    localparam int AW    = 9;
    localparam int BW    = 8;
    localparam int BIASW = 7;
    localparam int OW    = 17;
    localparam longint MAXV = (longint'(1) << OW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic [NCH*AW-1:0] in_a = '0;
    logic [NCH*BW-1:0] in_b = '0;
    logic [NCH-1:0]    in_gate = '0;
    logic [BIASW-1:0]  in_bias = '0;
    logic              in_acc_clr = 1'b0;
    logic              out_ready = 1'b0;

    logic              in_ready_w, out_valid_w, out_ovf_w;
    logic [OW-1:0]     out_data_w;
    logic              in_ready_s, out_valid_s, out_ovf_s;
    logic [OW-1:0]     out_data_s;

    int     n_assert = 0;
    int     n_fail   = 0;
    longint prev_w   = 0;
    longint prev_s   = 0;
    int     ta [NCH];
    int     tbv[NCH];

    always #5 clk = ~clk;

    gated_mac_seq #(.NCH(NCH), .AW(AW), .BW(BW), .BIASW(BIASW), .OW(OW), .SAT(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_a(in_a), .in_b(in_b), .in_gate(in_gate), .in_bias(in_bias),
        .in_acc_clr(in_acc_clr), .out_valid(out_valid_w), .out_ready(out_ready),
        .out_data(out_data_w), .out_ovf(out_ovf_w)
    );

    gated_mac_seq #(.NCH(NCH), .AW(AW), .BW(BW), .BIASW(BIASW), .OW(OW), .SAT(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_gate(in_gate), .in_bias(in_bias),
        .in_acc_clr(in_acc_clr), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_ovf(out_ovf_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NCH; i++) begin
            in_a[i*AW +: AW] = AW'(ta[i]);
            in_b[i*BW +: BW] = BW'(tbv[i]);
        end
    endtask

    task automatic set_ops(input int a_base, input int a_step, input int b_all);
        for (int i = 0; i < NCH; i++) begin
            ta[i]  = a_base + a_step * i;
            tbv[i] = b_all;
        end
    endtask

    // One full transaction; bp > 0 stalls DONE for bp cycles with fresh data offered.
    task automatic run_txn(input string tag, input logic [NCH-1:0] g, input int bias,
                           input bit clr, input int bp);
        longint sp, tot_w, tot_s, exp_w, exp_s;
        bit     ovf_w, ovf_s;
        sp = 0;
        for (int i = 0; i < NCH; i++)
            if (!g[i]) sp += longint'(ta[i]) * longint'(tbv[i]);
        tot_w = bias + (clr ? 0 : prev_w) + sp;
        tot_s = bias + (clr ? 0 : prev_s) + sp;
        exp_w = tot_w % (MAXV + 1);
        ovf_w = (tot_w > MAXV);
        exp_s = (tot_s > MAXV) ? MAXV : tot_s;
        ovf_s = (tot_s > MAXV);

        @(negedge clk);
        drive_ops();
        in_gate = g; in_bias = BIASW'(bias); in_acc_clr = clr; in_valid = 1'b1;
        chk({tag, "_in_ready_idle"}, 64'(in_ready_w), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_in_ready_busy"}, 64'(in_ready_w), 64'd0);
        repeat (NCH - 1) begin
            @(posedge clk); #1;
            chk({tag, "_early_valid"}, 64'(out_valid_w | out_valid_s), 64'd0);
        end
        @(posedge clk); #1;
        chk({tag, "_valid_w"}, 64'(out_valid_w), 64'd1);
        chk({tag, "_valid_s"}, 64'(out_valid_s), 64'd1);
        chk({tag, "_data_w"},  64'(out_data_w), 64'(exp_w));
        chk({tag, "_ovf_w"},   64'(out_ovf_w),  64'(ovf_w));
        chk({tag, "_data_s"},  64'(out_data_s), 64'(exp_s));
        chk({tag, "_ovf_s"},   64'(out_ovf_s),  64'(ovf_s));

        if (bp > 0) begin
            @(negedge clk);
            in_a = {NCH{9'h0AB}}; in_b = {NCH{8'h11}}; in_gate = '0;
            in_bias = 7'd99; in_acc_clr = 1'b1; in_valid = 1'b1;
            repeat (bp) begin
                @(posedge clk); #1;
                chk({tag, "_bp_valid"}, 64'(out_valid_w), 64'd1);
                chk({tag, "_bp_ready"}, 64'(in_ready_w | in_ready_s), 64'd0);
                chk({tag, "_bp_data"},  64'(out_data_w), 64'(exp_w));
                chk({tag, "_bp_ovf"},   64'(out_ovf_w),  64'(ovf_w));
            end
        end

        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_ready_after"}, 64'(in_ready_w & in_ready_s), 64'd1);
        chk({tag, "_valid_after"}, 64'(out_valid_w | out_valid_s), 64'd0);
        prev_w = exp_w;
        prev_s = exp_s;
    endtask

    initial begin
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready_w),  64'd1);
        chk("rst_out_valid", 64'(out_valid_w), 64'd0);
        chk("rst_out_data",  64'(out_data_w),  64'd0);
        chk("rst_out_ovf",   64'(out_ovf_w),   64'd0);
        chk("rst_out_data_s", 64'(out_data_s), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        set_ops(1, 1, 2);
        run_txn("basic", 6'b000000, 3, 1'b1, 0);
        run_txn("accum", 6'b000000, 3, 1'b0, 0);
        run_txn("reclr", 6'b000000, 3, 1'b1, 0);
        run_txn("allgate", 6'b111111, 5, 1'b1, 0);
        run_txn("gate101", 6'b000101, 3, 1'b1, 0);

        set_ops(511, 0, 255);
        run_txn("ovf", 6'b000000, 0, 1'b1, 0);
        set_ops(1, 1, 1);
        run_txn("satstick", 6'b000000, 2, 1'b0, 0);

        set_ops(7, 3, 5);
        run_txn("bp", 6'b010010, 11, 1'b1, 10);
        set_ops(1, 1, 2);
        run_txn("postbp", 6'b000000, 3, 1'b1, 0);

        // Reset while idx=3: the transaction vanishes and prev is cleared.
        @(negedge clk);
        drive_ops();
        in_gate = '0; in_bias = 7'd3; in_acc_clr = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid_w | out_valid_s), 64'd0);
        chk("midrst_ready", 64'(in_ready_w & in_ready_s), 64'd1);
        chk("midrst_data",  64'(out_data_w), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_w = 0;
        prev_s = 0;
        repeat (NCH + 2) begin
            @(posedge clk); #1;
            chk("midrst_no_out", 64'(out_valid_w | out_valid_s), 64'd0);
        end
        run_txn("postrst", 6'b000000, 3, 1'b0, 0);

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < NCH; i++) begin
                ta[i]  = int'($urandom_range(511, 0));
                tbv[i] = int'($urandom_range(255, 0));
            end
            run_txn("rand", NCH'($urandom), int'($urandom_range(127, 0)),
                    1'($urandom), (k % 5 == 0) ? 3 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
